button_event_queue: RTL and testbench
=====================================

# button_event_queue

Debounces the five push buttons and six slide switches, turns every debounced level change into a 16-bit event word, and queues those words in a small FIFO for the CPU. It sits directly upstream of the IO controller. The IO controller reads the head event and the live debounced status over the memory-mapped IO path, and pops the queue with a one-cycle strobe. This replaces polling raw button levels with a loss-detecting event stream.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles an input must hold a new level before it commits (10 ms at 50 MHz). Minimum 16.
- FIFO_DEPTH, 8: event queue depth. Power of two, 2–16.
- PTR_W, log2(FIFO_DEPTH): FIFO pointer width (derived).
- clk  in  1  system clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- button_up, button_left, button_center, button_right, button_down  in  1 each  raw asynchronous buttons; source index 0–4 in that order.
- switches  in  6  raw asynchronous switches; switches[k] has source index 5+k.
- pop  in  1  single-cycle read strobe from the IO controller.
- clear_overflow  in  1  clears the overflow flag.
- event_out  out  16  head of the FIFO (show-ahead). 16'h0000 when the FIFO is empty.
- status_out  out  16  live debounced levels: {5'b0, switches_db[5:0], buttons_db[4:0]}.
- count  out  PTR_W+1  number of queued events.
- overflow  out  1  sticky flag, set when an event is dropped.

## Operation
- **Input conditioning.** Each of the 11 inputs goes through a 2-flop synchronizer, then a debounce cell (stable level plus counter).
  - If sync ≠ stable, the counter increments. When the counter reaches DEBOUNCE_CYCLES−1 while sync still ≠ stable: stable ← sync, counter ← 0, commit pulse.
  - If sync == stable, the counter ← 0. Any bounce restarts the count.
- **Pending events.** A commit sets pending[i] and records pend_lvl[i] = new stable level.
- **Arbiter.** Each cycle, the lowest-index set pending bit is pushed and cleared. At most one push per cycle.
- **Event word format.**
  - [15] = 1 (valid).
  - [8] = level: 1 = pressed / switch on.
  - [3:0] = source index.
  - All other bits are 0.
- **Push and pop rules.**
  - Push when not full: write at the write pointer, count +1.
  - Push when full with no pop: the event is dropped, its pending bit is still cleared, and overflow ← 1.
  - pop when count = 0: ignored.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also holds when full: the push is accepted.
- **Overflow flag.** Stays set until clear_overflow or reset. If clear_overflow and a drop happen in the same cycle, overflow ends at 1.
- **Pointers.** Wrap modulo FIFO_DEPTH. count is PTR_W+1 bits, so full is count == FIFO_DEPTH.
- **Reset values.** All outputs are 0 (event_out 16'h0000, status_out 0, count 0, overflow 0). Synchronizers, stable levels, counters, pending bits and pointers are also cleared.
  - Inputs already high at reset therefore produce "on" events after debounce. This is intended: software learns the initial switch positions this way.
- **Reset mid-debounce** discards the partial count and any pending event.

## Timing
- Let edge 0 be the first clock edge sampling a new raw level.
  - Synchronizer output is valid after edge 1.
  - Commit happens at edge 1+DEBOUNCE_CYCLES.
  - Push happens at edge 2+DEBOUNCE_CYCLES.
  - event_out and count update after that same edge.
- status_out changes at the commit edge, one cycle before the event is visible.
- Simultaneous commits on n inputs reach the FIFO over n consecutive cycles, in ascending index order.
- DEBOUNCE_CYCLES ≥ 16 guarantees the pending set drains (≤ 11 cycles) before any input can commit again, so pending is never overwritten.
- pop takes effect at the next edge: event_out shows the next entry, or 0, one cycle after the strobe.

## Structure
- **Shared package (io_pkg):**
  - Source index constants (SRC_UP … SRC_SW5).
  - Event bit positions (EV_VALID_BIT = 15, EV_LEVEL_BIT = 8, EV_SRC_LSB = 0, EV_SRC_W = 4).
  - NUM_SOURCES = 11.
  - Default debounce constant.
- **Sub-module debounce_cell:** synchronizer, counter and stable level, with a commit output. Instantiated 11 times.
- **Inline in this block:** pending/arbiter logic and the FIFO (register array).

## Test plan
1. **Initial switch state.** DEBOUNCE_CYCLES = 16, switches = 6'b000001 held through reset release → after edge 18: event_out = 16'h8105, count = 1, status_out = 16'h0020.
2. **Bounce rejection.** button_up toggles every 5 cycles for 40 cycles, then holds 1 → exactly one event 16'h8100. Holding 0 later → one event 16'h8000.
3. **Simultaneous commits.** button_center and switches[3] rise in the same cycle → events 16'h8102 then 16'h8108 on consecutive cycles; count reaches 2.
4. **Overflow.** Generate 9 events with no pop → count = 8, overflow = 1, the 9th event is absent. Pulse clear_overflow → overflow = 0.
5. **Push/pop collision when full.** FIFO full; pop in the same cycle as a push → count stays 8, FIFO order preserved, overflow stays 0.
6. **Empty pop and reset mid-debounce.** pop while empty → count = 0, event_out = 16'h0000. Assert reset halfway through a debounce → no event is ever produced.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the button/switch event path: source indices,
// event word layout and the default debounce length.
package io_pkg;

    localparam int unsigned NUM_SOURCES      = 11;
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

    localparam int unsigned SRC_UP     = 0;
    localparam int unsigned SRC_LEFT   = 1;
    localparam int unsigned SRC_CENTER = 2;
    localparam int unsigned SRC_RIGHT  = 3;
    localparam int unsigned SRC_DOWN   = 4;
    localparam int unsigned SRC_SW0    = 5;
    localparam int unsigned SRC_SW1    = 6;
    localparam int unsigned SRC_SW2    = 7;
    localparam int unsigned SRC_SW3    = 8;
    localparam int unsigned SRC_SW4    = 9;
    localparam int unsigned SRC_SW5    = 10;

    localparam int unsigned EV_W         = 16;
    localparam int unsigned EV_VALID_BIT = 15;
    localparam int unsigned EV_LEVEL_BIT = 8;
    localparam int unsigned EV_SRC_LSB   = 0;
    localparam int unsigned EV_SRC_W     = 4;

    // Builds a valid event word for one source and its new level.
    function automatic logic [EV_W-1:0] make_event(input logic [EV_SRC_W-1:0] src,
                                                   input logic level);
        logic [EV_W-1:0] ev;
        ev                           = '0;
        ev[EV_VALID_BIT]             = 1'b1;
        ev[EV_LEVEL_BIT]             = level;
        ev[EV_SRC_LSB +: EV_SRC_W]   = src;
        return ev;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input's 2-flop synchronizer plus counter-based debouncer; commit_c
// pulses in the cycle the stable level is about to change.
module debounce_cell
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic commit_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign commit_c = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample matching the stable level restarts the hold count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (commit_c) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// Debounces 5 buttons and 6 switches, converts each committed level change
// into an event word, and queues events in a show-ahead FIFO for the CPU.
module button_event_queue
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned PTR_W           = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_up,
    input  logic             button_left,
    input  logic             button_center,
    input  logic             button_right,
    input  logic             button_down,
    input  logic [5:0]       switches,
    input  logic             pop,
    input  logic             clear_overflow,
    output logic [EV_W-1:0]  event_out,
    output logic [EV_W-1:0]  status_out,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    logic [NUM_SOURCES-1:0] raw;
    logic [NUM_SOURCES-1:0] level;
    logic [NUM_SOURCES-1:0] commit;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] pend_lvl;
    logic [NUM_SOURCES-1:0] grant;

    logic [EV_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;

    logic                   push_req;
    logic                   push_level;
    logic [EV_SRC_W-1:0]    push_src;
    logic [EV_W-1:0]        push_word;
    logic                   full;
    logic                   pop_eff;
    logic                   push_ok;
    logic                   drop;
    logic [PTR_W:0]         count_n;
    logic [EV_W-1:0]        head_n;

    assign raw        = {switches, button_down, button_right, button_center,
                         button_left, button_up};
    assign status_out = {5'b0, level};

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_db
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw[g]),
            .level    (level[g]),
            .commit_c (commit[g])
        );
    end

    // Fixed-priority arbiter: lowest pending index wins the single push slot.
    always_comb begin
        grant      = '0;
        push_req   = 1'b0;
        push_level = 1'b0;
        push_src   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (pending[i] && !push_req) begin
                push_req   = 1'b1;
                grant[i]   = 1'b1;
                push_level = pend_lvl[i];
                push_src   = EV_SRC_W'(i);
            end
        end
    end

    assign push_word = make_event(push_src, push_level);
    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop_eff   = pop && (count != '0);
    assign push_ok   = push_req && (!full || pop_eff);
    assign drop      = push_req && full && !pop_eff;

    // Next count and next show-ahead head word.
    always_comb begin
        count_n = count;
        if (push_ok && !pop_eff) begin
            count_n = count + (PTR_W + 1)'(1);
        end else if (!push_ok && pop_eff) begin
            count_n = count - (PTR_W + 1)'(1);
        end

        head_n = event_out;
        if (count_n == '0) begin
            head_n = '0;
        end else if ((count == '0) || (pop_eff && count == (PTR_W + 1)'(1))) begin
            head_n = push_word;
        end else if (pop_eff) begin
            head_n = mem[rd_ptr + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            pend_lvl  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            event_out <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pending  <= (pending & ~grant) | commit;
            pend_lvl <= (pend_lvl & ~commit) | (commit & ~level);
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_n;
            event_out <= head_n;
            // A drop in the same cycle as a clear still leaves the flag set.
            overflow  <= drop | (overflow & ~clear_overflow);
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed plus randomized checks of button_event_queue against a
// sample-window debounce model and a queue-based FIFO model.
module tb_button_event_queue;

    localparam int unsigned D     = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NS    = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        button_up, button_left, button_center, button_right, button_down;
    logic [5:0]  switches;
    logic        pop;
    logic        clear_overflow;
    logic [15:0] event_out;
    logic [15:0] status_out;
    logic [3:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [NS-1:0] s1_m, s2_m, stable_m, pend_m, plvl_m;
    logic [D-1:0]  hist_m [NS];
    logic [15:0]   q_m [$];
    logic          ovf_m;

    button_event_queue #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .button_up      (button_up),
        .button_left    (button_left),
        .button_center  (button_center),
        .button_right   (button_right),
        .button_down    (button_down),
        .switches       (switches),
        .pop            (pop),
        .clear_overflow (clear_overflow),
        .event_out      (event_out),
        .status_out     (status_out),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [NS-1:0] raw_now();
        return {switches, button_down, button_right, button_center, button_left, button_up};
    endfunction

    task automatic set_raw(input logic [NS-1:0] r);
        button_up     = r[0];
        button_left   = r[1];
        button_center = r[2];
        button_right  = r[3];
        button_down   = r[4];
        switches      = r[10:5];
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s1_m = '0; s2_m = '0; stable_m = '0; pend_m = '0; plvl_m = '0;
        for (int i = 0; i < NS; i++) hist_m[i] = '0;
        q_m.delete();
        ovf_m = 1'b0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [NS-1:0] r;
        logic          preq;
        logic          dropped;
        logic          pe;
        logic [15:0]   w;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            r = raw_now();
            preq = 1'b0; dropped = 1'b0; w = '0;
            for (int i = 0; i < NS; i++) begin
                if (pend_m[i] && !preq) begin
                    preq      = 1'b1;
                    pend_m[i] = 1'b0;
                    w = 16'h8000 | (16'(plvl_m[i]) << 8) | 16'(i);
                end
            end
            pe = pop && (q_m.size() > 0);
            if (pe) void'(q_m.pop_front());
            if (preq) begin
                if (q_m.size() < DEPTH) q_m.push_back(w);
                else dropped = 1'b1;
            end
            if (dropped) ovf_m = 1'b1;
            else if (clear_overflow) ovf_m = 1'b0;
            // A level commits once the last D synchronized samples all disagree with it.
            for (int i = 0; i < NS; i++) begin
                hist_m[i] = {hist_m[i][D-2:0], s2_m[i]};
                if (hist_m[i] == {D{~stable_m[i]}}) begin
                    stable_m[i] = ~stable_m[i];
                    pend_m[i]   = 1'b1;
                    plvl_m[i]   = stable_m[i];
                end
            end
            s2_m = s1_m;
            s1_m = r;
        end
        #1;
        chk("event_out", event_out, (q_m.size() > 0) ? q_m[0] : 16'h0000);
        chk("count", 16'(count), 16'(q_m.size()));
        chk("overflow", 16'(overflow), 16'(ovf_m));
        chk("status_out", status_out, {5'b0, stable_m});
    endtask

    task automatic pulse_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] flips;
        reset = 1'b1;
        set_raw('0);
        switches       = 6'b000001;
        pop            = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_event", event_out, 16'h0000);
        chk("rst_count", 16'(count), 16'h0000);
        chk("rst_status", status_out, 16'h0000);

        // Initial switch position reported after reset release
        reset = 1'b0;
        repeat (19) step();
        chk("t1_event", event_out, 16'h8105);
        chk("t1_count", 16'(count), 16'h0001);
        chk("t1_status", status_out, 16'h0020);
        pulse_pop();

        // Bounce rejection
        for (int k = 0; k < 8; k++) begin
            button_up = ~button_up;
            repeat (5) step();
        end
        chk("t2_no_event", 16'(count), 16'h0000);
        button_up = 1'b1;
        repeat (D + 6) step();
        chk("t2_press_count", 16'(count), 16'h0001);
        chk("t2_press_event", event_out, 16'h8100);
        pulse_pop();
        button_up = 1'b0;
        repeat (D + 6) step();
        chk("t2_release_count", 16'(count), 16'h0001);
        chk("t2_release_event", event_out, 16'h8000);
        pulse_pop();

        // Simultaneous commits drain in index order
        button_center = 1'b1;
        switches[3]   = 1'b1;
        repeat (D + 3) step();
        chk("t3_first_event", event_out, 16'h8102);
        chk("t3_first_count", 16'(count), 16'h0001);
        step();
        chk("t3_second_count", 16'(count), 16'h0002);
        pulse_pop();
        chk("t3_second_event", event_out, 16'h8108);
        pulse_pop();
        chk("t3_empty", event_out, 16'h0000);

        // Nine events into an eight-deep queue
        button_up = 1'b1; button_left = 1'b1; button_right = 1'b1; button_down = 1'b1;
        button_center = 1'b0;
        switches = 6'b111111;
        repeat (D + 14) step();
        chk("t4_count", 16'(count), 16'h0008);
        chk("t4_overflow", 16'(overflow), 16'h0001);
        chk("t4_head", event_out, 16'h8100);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("t4_cleared", 16'(overflow), 16'h0000);

        // Push and pop together while full
        button_up = 1'b0;
        repeat (D + 2) step();
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("t5_count", 16'(count), 16'h0008);
        chk("t5_overflow", 16'(overflow), 16'h0000);
        chk("t5_head", event_out, 16'h8101);
        repeat (7) pulse_pop();
        chk("t5_last", event_out, 16'h8000);
        pulse_pop();
        chk("t5_drained", 16'(count), 16'h0000);

        // Pop on empty, then reset in the middle of a debounce
        pulse_pop();
        chk("t6_empty_count", 16'(count), 16'h0000);
        chk("t6_empty_event", event_out, 16'h0000);
        set_raw('0);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        button_down = 1'b1;
        repeat (D / 2) step();
        reset = 1'b1;
        button_down = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (3 * D) step();
        chk("t6_no_event_count", 16'(count), 16'h0000);
        chk("t6_no_event_word", event_out, 16'h0000);
        chk("t6_no_overflow", 16'(overflow), 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            flips = '0;
            for (int i = 0; i < NS; i++) flips[i] = ($urandom_range(0, 39) == 0);
            set_raw(raw_now() ^ flips);
            pop            = ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 63) == 0);
            step();
        end
        pop = 1'b0;
        clear_overflow = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
